// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_sb register file and load scoreboard.
// Pair-operation encodings on the pair_op input.
package regfile_pkg;

    typedef enum logic [1:0] {
        PAIR_NONE = 2'b00,
        PAIR_ADD  = 2'b01,
        PAIR_MOVE = 2'b10,
        PAIR_RSVD = 2'b11
    } pair_op_e;

endpackage

// File: rtl/ld_tag_fifo.sv
// In-order tag FIFO holding destination selects of outstanding loads.
// The caller must not push when full unless it also pops, and never pops when empty.
module ld_tag_fifo #(
    parameter int LD_DEPTH = 4,
    parameter int AW       = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_tag,
    output logic [AW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int IW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int CW = $clog2(LD_DEPTH + 1);

    logic [AW-1:0] mem [LD_DEPTH];
    logic [IW-1:0] rd_ptr;
    logic [IW-1:0] wr_ptr;
    logic [CW-1:0] count;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(LD_DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(LD_DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with even/odd pair ADD/MOVE, ALU write port and in-order load scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle load/ALU writes to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NREGS    = 16,
    parameter int LD_DEPTH = 4,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [AW-1:0]       a_sel,
    input  logic [AW-1:0]       b_sel,
    input  logic                rd_a_en,
    input  logic                rd_b_en,
    output logic [DATA_W-1:0]   out_a,
    output logic [DATA_W-1:0]   out_b,
    output logic [2*DATA_W-1:0] out_pair_b,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_sel,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [1:0]          pair_op,
    input  logic [DATA_W-1:0]   constant,
    input  logic                ld_issue,
    input  logic [AW-1:0]       ld_sel,
    output logic                ld_issue_ready,
    input  logic                ld_rsp_valid,
    input  logic [DATA_W-1:0]   ld_rsp_data,
    output logic                stall,
    output logic [NREGS-1:0]    busy,
    output logic                ld_err
);

    logic [DATA_W-1:0]   rf       [NREGS];
    logic [DATA_W-1:0]   rsp_view [NREGS];
    logic [DATA_W-1:0]   rd_view  [NREGS];
    logic [NREGS-1:0]    busy_q;
    logic [NREGS-1:0]    hz_busy;
    logic [NREGS-1:0]    rsp_mask;
    logic [NREGS-1:0]    pair_mask;
    logic [NREGS-1:0]    wr_mask;
    logic                ld_err_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic [AW-1:0]       head_tag;
    logic                pop;
    logic                push;

    logic [AW-2:0]       pa;
    logic [AW-2:0]       pb;
    logic [AW-1:0]       a_lo, a_hi, b_lo, b_hi;
    logic                op_add;
    logic                op_move;
    logic                pair_en;
    logic                wr_go;
    logic [2*DATA_W-1:0] src_a;
    logic [2*DATA_W-1:0] src_b;
    logic [2*DATA_W-1:0] const_ext;
    logic [2*DATA_W-1:0] pair_res;

    ld_tag_fifo #(
        .LD_DEPTH (LD_DEPTH),
        .AW       (AW)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .push_tag (ld_sel),
        .head     (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign pop            = ld_rsp_valid & ~fifo_empty;
    assign ld_issue_ready = ~fifo_full | pop;
    assign rsp_mask       = pop ? (NREGS'(1) << head_tag) : '0;

`ifdef REGFILE_BYPASS_EN
    assign hz_busy = busy_q & ~rsp_mask;
`else
    assign hz_busy = busy_q;
`endif

    assign pa      = a_sel[AW-1:1];
    assign pb      = b_sel[AW-1:1];
    assign a_lo    = {pa, 1'b0};
    assign a_hi    = {pa, 1'b1};
    assign b_lo    = {pb, 1'b0};
    assign b_hi    = {pb, 1'b1};
    assign op_add  = (pair_op == PAIR_ADD);
    assign op_move = (pair_op == PAIR_MOVE);

    always_comb begin
        stall = 1'b0;
        if (rd_a_en && hz_busy[a_sel])                              stall = 1'b1;
        if (rd_b_en && hz_busy[b_sel])                              stall = 1'b1;
        if (wr_en && hz_busy[wr_sel])                               stall = 1'b1;
        if ((op_add || op_move) && (hz_busy[a_lo] || hz_busy[a_hi])) stall = 1'b1;
        if (op_move && (hz_busy[b_lo] || hz_busy[b_hi]))            stall = 1'b1;
        if (ld_issue && (hz_busy[ld_sel] || !ld_issue_ready))       stall = 1'b1;
    end

    assign pair_en = (op_add | op_move) & ~stall;
    assign wr_go   = wr_en & ~stall;
    assign push    = ld_issue & ~stall;

    // Pair operands see the word arriving from memory this cycle.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            rsp_view[i] = rsp_mask[i] ? ld_rsp_data : rf[i];
        end
    end

    assign src_a     = {rsp_view[a_hi], rsp_view[a_lo]};
    assign src_b     = {rsp_view[b_hi], rsp_view[b_lo]};
    assign const_ext = {{DATA_W{constant[DATA_W-1]}}, constant};
    assign pair_res  = op_add ? (src_a + const_ext) : src_b;
    assign pair_mask = pair_en ? (NREGS'(3) << a_lo) : '0;
    assign wr_mask   = wr_go ? (NREGS'(1) << wr_sel) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (rsp_mask[i]) begin
                    rf[i] <= ld_rsp_data;
                end else if (pair_mask[i]) begin
                    rf[i] <= (i % 2 == 1) ? pair_res[2*DATA_W-1:DATA_W] : pair_res[DATA_W-1:0];
                end else if (wr_mask[i]) begin
                    rf[i] <= wr_data;
                end
            end
        end
    end

    // A push to the register being popped keeps it busy: the new load is still pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= '0;
            ld_err_q <= 1'b0;
        end else begin
            busy_q <= (busy_q & ~rsp_mask) | (push ? (NREGS'(1) << ld_sel) : '0);
            if (ld_rsp_valid && fifo_empty) begin
                ld_err_q <= 1'b1;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (rsp_mask[i]) begin
                rd_view[i] = ld_rsp_data;
            end else if (wr_mask[i] && !pair_mask[i]) begin
                rd_view[i] = wr_data;
            end else begin
                rd_view[i] = rf[i];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            rd_view[i] = rf[i];
        end
    end
`endif

    assign out_a      = rd_view[a_sel];
    assign out_b      = rd_view[b_sel];
    assign out_pair_b = {rd_view[b_hi], rd_view[b_lo]};
    assign busy       = busy_q;
    assign ld_err     = ld_err_q;

endmodule
